// File: rtl/ddr2_input_packer_fifo.sv
// ddr2_input_packer_fifo
// Packs pairs of 16-bit acquisition words into 32-bit words and buffers them
// in a single-clock block-RAM FIFO read by the DDR2 burst state machine.
// Read path: the RAM output register is loaded on the pop-acceptance edge and
// ib_data/ib_valid are registered one edge later. Overflow/underflow are sticky
// until flush or reset.

module ddr2_input_packer_fifo #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       din,
    input  logic              din_we,
    input  logic              flush,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    input  logic              ib_re,
    output logic [31:0]       ib_data,
    output logic              ib_valid,
    output logic              ib_empty,
    output logic [ADDR_W-1:0] ib_count
);

    // Packer states, carried by half_valid_r.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HALF  = 1'b1;

    localparam logic [ADDR_W-1:0] CNT_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_MAX  = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] count_r;
    logic [0:0]        half_valid_r;
    logic [15:0]       half_data_r;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              pop_d_r;
    logic              ib_valid_r;
    logic [31:0]       ib_data_r;
    logic [31:0]       mem_q_r;
    logic [31:0]       mem_r [DEPTH];

    logic              pair_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       packed_s;
    logic [ADDR_W-1:0] count_nxt_s;

    // Push/pop qualification; flush suppresses both.
    always_comb begin
        pair_s   = (half_valid_r == HALF) && din_we;
        push_s   = pair_s && !full_r && !flush;
        pop_s    = ib_re && !empty_r && !flush;
        packed_s = {din, half_data_r};
    end

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Block RAM: one write port, synchronous read into the RAM output register.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= packed_s;
        end
        if (pop_s) begin
            mem_q_r <= mem_r[rd_ptr_r];
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= CNT_ZERO;
            rd_ptr_r <= CNT_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (flush) begin
            wr_ptr_r <= CNT_ZERO;
            rd_ptr_r <= CNT_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + CNT_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + CNT_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_MAX);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    // Half-word packer; a dropped pair still returns to EMPTY to keep alignment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_valid_r <= EMPTY;
            half_data_r  <= 16'h0000;
        end else if (flush) begin
            half_valid_r <= EMPTY;
        end else if (din_we) begin
            case (half_valid_r)
                EMPTY: begin
                    half_data_r  <= din;
                    half_valid_r <= HALF;
                end
                HALF: begin
                    half_valid_r <= EMPTY;
                end
                default: begin
                    half_valid_r <= EMPTY;
                end
            endcase
        end
    end

    // Sticky overflow/underflow traps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (pair_s && full_r) begin
                overflow_r <= 1'b1;
            end
            if (ib_re && empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Read output stage: data and one-cycle valid one edge after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_d_r    <= 1'b0;
            ib_valid_r <= 1'b0;
            ib_data_r  <= 32'h0000_0000;
        end else if (flush) begin
            pop_d_r    <= 1'b0;
            ib_valid_r <= 1'b0;
        end else begin
            pop_d_r    <= pop_s;
            ib_valid_r <= pop_d_r;
            if (pop_d_r) begin
                ib_data_r <= mem_q_r;
            end
        end
    end

    assign full      = full_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign ib_data   = ib_data_r;
    assign ib_valid  = ib_valid_r;
    assign ib_empty  = empty_r;
    assign ib_count  = count_r;

endmodule

// File: tb/tb_ddr2_input_packer_fifo.sv
// Testbench for ddr2_input_packer_fifo: a vector table for the short
// read/underflow/flush sequences, then hand-written fill, drain/wrap,
// simultaneous push/pop and asynchronous-reset sequences checked against
// an expected-word queue.

module tb_ddr2_input_packer_fifo;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        din_we;
    logic        flush;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic        ib_re;
    logic [31:0] ib_data;
    logic        ib_valid;
    logic        ib_empty;
    logic [10:0] ib_count;

    int total = 0;
    int bad   = 0;
    bit sb_en = 1'b0;
    int n_valid = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [15:0] d;
        logic        re;
        logic        fl;
        logic [10:0] cnt;
        logic        emp;
        logic        vld;
        logic        uf;
        logic [31:0] dat;
    } vec_t;

    vec_t vecs[17];

    ddr2_input_packer_fifo #(.DEPTH(2048), .ADDR_W(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_we    (din_we),
        .flush     (flush),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .ib_re     (ib_re),
        .ib_data   (ib_data),
        .ib_valid  (ib_valid),
        .ib_empty  (ib_empty),
        .ib_count  (ib_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, wait for the edge, sample 1 time unit later.
    task automatic cyc(input logic we, input logic [15:0] d, input logic re, input logic fl);
        logic [31:0] e;
        din_we = we;
        din    = d;
        ib_re  = re;
        flush  = fl;
        @(posedge clk);
        #1;
        if (sb_en && ib_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", ib_data, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", ib_data, e);
            end
        end
        din_we = 1'b0;
        ib_re  = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_cnt"},   {21'd0, ib_count}, 32'd0);
        chk({name, "_flags"}, {27'd0, ib_empty, full, ib_valid, overflow, underflow}, 32'b10000);
        chk({name, "_data"},  ib_data, 32'h0000_0000);
    endtask

    initial begin
        reset  = 1'b0;
        din    = 16'h0000;
        din_we = 1'b0;
        flush  = 1'b0;
        ib_re  = 1'b0;

        //           we    d         re    fl    cnt    emp   vld   uf    dat
        vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 32'h2222_1111};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 32'h2222_1111};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 32'h2222_1111};
        vecs[7]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 32'h2222_1111};
        vecs[8]  = '{1'b1, 16'h5678, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b1, 32'h2222_1111};
        vecs[9]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b1, 32'h2222_1111};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 32'h2222_1111};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'h2222_1111};
        vecs[12] = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'h2222_1111};
        vecs[13] = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b0, 32'h2222_1111};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b0, 32'h2222_1111};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'h2222_1111};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 32'hCCCC_BBBB};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        #3;
        reset = 1'b1;

        // Table: empty read, underflow, flush mid-pair and mid-read
        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].we, vecs[i].d, vecs[i].re, vecs[i].fl);
            chk($sformatf("vec%0d_status", i),
                {18'd0, ib_count, ib_empty, ib_valid, underflow, full, overflow},
                {18'd0, vecs[i].cnt, vecs[i].emp, vecs[i].vld, vecs[i].uf, 1'b0, 1'b0});
            chk($sformatf("vec%0d_data", i), ib_data, vecs[i].dat);
        end

        // Fill to capacity: 4094 half-words, din = index
        sb_en = 1'b1;
        for (int i = 0; i < 4094; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0);
            if (i % 2 == 1) exp_q.push_back({16'(i), 16'(i - 1)});
            if (i == 4091) chk("full_at_2046", {31'd0, full}, 32'd0);
        end
        chk("fill_cnt", {21'd0, ib_count}, 32'd2047);
        chk("fill_full", {30'd0, full, overflow}, 32'b10);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_cnt", {21'd0, ib_count}, 32'd2047);

        // Drain 2047 words back-to-back
        n_valid = 0;
        for (int i = 0; i < 2047; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("drain_nvalid", 32'(n_valid), 32'd2047);
        chk("drain_last", ib_data, 32'h0FFD_0FFC);
        chk("drain_empty", {20'd0, ib_count, ib_empty}, {20'd0, 11'd0, 1'b1});

        // Ten more words across the pointer wrap
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 16'h5000 + 16'(2 * j), 1'b0, 1'b0);
            cyc(1'b1, 16'h5001 + 16'(2 * j), 1'b0, 1'b0);
            exp_q.push_back({16'h5001 + 16'(2 * j), 16'h5000 + 16'(2 * j)});
        end
        chk("wrap_cnt", {21'd0, ib_count}, 32'd10);
        for (int j = 0; j < 10; j++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("wrap_empty", {20'd0, ib_count, ib_empty}, {20'd0, 11'd0, 1'b1});
        chk("wrap_q", 32'(exp_q.size()), 32'd0);

        // Simultaneous push and pop at count 64
        for (int j = 0; j < 64; j++) begin
            cyc(1'b1, 16'h6000 + 16'(2 * j), 1'b0, 1'b0);
            cyc(1'b1, 16'h6001 + 16'(2 * j), 1'b0, 1'b0);
            exp_q.push_back({16'h6001 + 16'(2 * j), 16'h6000 + 16'(2 * j)});
        end
        chk("sim_cnt64", {21'd0, ib_count}, 32'd64);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 16'h7000 + 16'(2 * j), 1'b0, 1'b0);
            chk("sim_half_cnt", {21'd0, ib_count}, 32'd64);
            exp_q.push_back({16'h7001 + 16'(2 * j), 16'h7000 + 16'(2 * j)});
            cyc(1'b1, 16'h7001 + 16'(2 * j), 1'b1, 1'b0);
            chk("sim_pushpop_cnt", {21'd0, ib_count}, 32'd64);
        end
        for (int j = 0; j < 64; j++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("sim_empty", {20'd0, ib_count, ib_empty}, {20'd0, 11'd0, 1'b1});
        chk("sim_q", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset at count 100 with a half-word pending
        for (int j = 0; j < 100; j++) begin
            cyc(1'b1, 16'h8000 + 16'(j), 1'b0, 1'b0);
            cyc(1'b1, 16'h9000 + 16'(j), 1'b0, 1'b0);
        end
        cyc(1'b1, 16'hEEEE, 1'b0, 1'b0);
        chk("pre_rst_cnt", {21'd0, ib_count}, 32'd100);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_state("async_rst");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 16'h7777, 1'b0, 1'b0);
        cyc(1'b1, 16'h8888, 1'b0, 1'b0);
        exp_q.push_back(32'h8888_7777);
        chk("post_rst_cnt", {21'd0, ib_count}, 32'd1);
        n_valid = 0;
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("post_rst_nvalid", 32'(n_valid), 32'd1);
        chk("post_rst_data", ib_data, 32'h8888_7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr2_input_packer_fifo.md
# ddr2_input_packer_fifo

Write-side buffer in front of the DDR2 burst state machine. Packs 16-bit acquisition words pairwise into 32-bit words, stores them in a 2048-entry single-clock FIFO, and presents the `ib_re` / `ib_data` / `ib_valid` / `ib_empty` / `ib_count` read interface the state machine consumes when it drains bursts to DRAM. Overflow and underflow are trapped in sticky flags for host readout.

## Interface
- `DEPTH`, 2048: storage entries, power of two; usable capacity `DEPTH-1`.
- `ADDR_W`, 11: log2(`DEPTH`); also width of `ib_count`.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low. 0 = reset.
- `din` in 16: acquisition word.
- `din_we` in 1: `din` valid this cycle.
- `flush` in 1: synchronous clear of FIFO contents, packer half-word and sticky flags.
- `full` out 1: FIFO holds `DEPTH-1` words.
- `overflow` out 1: sticky; a packed word was dropped while `full`.
- `underflow` out 1: sticky; `ib_re` was asserted while `ib_empty`.
- `ib_re` in 1: pop request from the DDR state machine.
- `ib_data` out 32: popped word, registered.
- `ib_valid` out 1: `ib_data` holds a freshly popped word. One-cycle pulse.
- `ib_empty` out 1: FIFO holds 0 words.
- `ib_count` out `ADDR_W`: stored words, 0..`DEPTH-1`.

## Operation
- Reset (`reset`=0, asynchronous) values:
  - `wr_ptr`, `rd_ptr`, `ib_count` = 0
  - `half_valid` = 0
  - `ib_data` = 0
  - `ib_valid`, `full`, `overflow`, `underflow` = 0
  - `ib_empty` = 1
- Packer has two states, `EMPTY` and `HALF`, tracked by `half_valid`:
  - `EMPTY` + `din_we`: latch `din` into `half_data` and go to `HALF`.
  - `HALF` + `din_we`: form `{din, half_data}` (first word in bits [15:0]) and go to `EMPTY`.
    - If not `full`, push the word.
    - If `full`, drop the word and set `overflow`. The packer still returns to `EMPTY`, so pairing stays aligned.
- Push: write memory at `wr_ptr`, then `wr_ptr` += 1 (mod `DEPTH`).
- Pop: accepted when `ib_re` && !`ib_empty`. Read memory at `rd_ptr`, then `rd_ptr` += 1 (mod `DEPTH`).
- `ib_re` while `ib_empty`: no pointer change, no `ib_valid`, set `underflow`.
- `ib_count` update per cycle:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged.
  - Neither: unchanged.
- Flags are registered, derived from the next value of `ib_count`:
  - `full` = (`ib_count` == `DEPTH-1`).
  - `ib_empty` = (`ib_count` == 0).
- Pointer wrap from `DEPTH-1` to 0 is natural binary rollover. `ib_count` never wraps.
- `flush` takes priority over push, pop, `din_we` and `ib_re` in the same cycle.
  - Clears pointers, count, `half_valid`, `overflow`, `underflow`.
  - Forces `ib_valid`=0 on the next cycle. `ib_data` holds its value.
- Memory contents are not reset. Inference as block RAM is required: synchronous read, one write port.

## Timing
- The push edge is the edge where the second half-word is sampled. `ib_count` and `ib_empty` reflect the push immediately after that edge.
- `ib_re` may be asserted in the cycle after the push at the earliest.
- Read latency is 1 cycle:
  - `ib_re` accepted at edge N.
  - `ib_data` and `ib_valid`=1 are registered at edge N+1, so they are visible during cycle N+1.
  - `ib_valid` drops after one cycle unless another pop was accepted at edge N+1.
- Back-to-back `ib_re` on consecutive cycles gives one word per cycle with `ib_valid` held high. The DDR state machine's re/wait pattern (one pop every 3 cycles) is also supported.
- `ib_count` decrements at the pop-acceptance edge, not when `ib_valid` asserts.
- Sustained `din_we` every cycle produces one push every 2 cycles.
- `reset` deassertion is synchronised externally. First legal `din_we` is the first edge after release.

## Test plan
- **Reset and empty read.** `din_we` 0x1111, 0x2222, then `ib_re` on the second cycle after the push edge.
  - `ib_count` = 1, then 0.
  - `ib_data` = 0x2222_1111 with `ib_valid` = 1 for exactly one cycle.
  - A further `ib_re` sets `underflow`, and `ib_valid` stays 0.
- **Fill to capacity.** Write 4094 half-words (`din` = index) with no reads.
  - `ib_count` = 2047, `full` = 1, `overflow` = 0.
  - Two more half-words: `overflow` = 1 and `ib_count` stays 2047.
- **Drain and wrap.** From full, assert `ib_re` for 2047 consecutive cycles, then write and read 10 more words.
  - Data is in order, ending 0x0FFD_0FFC.
  - Pointers wrap.
  - Post-wrap data is correct, and `ib_empty` = 1 at the end.
- **Simultaneous push and pop.** At `ib_count` = 64, run paired half-words together with an `ib_re` pattern so that a push and a pop land on the same edge.
  - `ib_count` stays 64 on that edge.
  - The order of the `ib_valid` data is preserved.
- **Flush mid-pair and mid-read.** Sequence: `din_we` 0xAAAA, then `flush` together with `ib_re`, then `din_we` 0xBBBB, 0xCCCC.
  - `ib_count` = 0 after the flush, with no `ib_valid` pulse from the flushed pop.
  - Then `ib_count` = 1 and the stored word is 0xCCCC_BBBB (0xAAAA is discarded).
- **Asynchronous reset mid-operation.** Assert `reset` = 0 between clock edges while `ib_count` = 100 and `half_valid` = 1.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, the next word pair is packed from a clean `EMPTY` state.
